// File: rtl/sram_like_dmem_pkg.sv
// sram_like_dmem_pkg: shared SRAM-like bus widths and access-size encodings
package sram_like_dmem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W = 3;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;
endpackage

// File: rtl/sram_like_dmem_if.sv
// sram_like_dmem_if: SRAM-like data-port bundle between CPU master and memory slave
interface sram_like_dmem_if;
  import sram_like_dmem_pkg::*;
  logic req;
  logic wr;
  size_e size;
  logic [ADDR_W-1:0] addr;
  logic [STRB_W-1:0] wstrb;
  logic [DATA_W-1:0] wdata;
  logic addr_ok;
  logic data_ok;
  logic [DATA_W-1:0] rdata;
  logic resp_hold;
  modport master(output req, wr, size, addr, wstrb, wdata, resp_hold, input addr_ok, data_ok, rdata);
  modport slave(input req, wr, size, addr, wstrb, wdata, resp_hold, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/dmem_resp_queue.sv
// dmem_resp_queue: in-order FIFO of accepted requests, each with its own response countdown
module dmem_resp_queue
  import sram_like_dmem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter logic [CNT_W-1:0] DELAY = 3'd1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic              push_wr,
  input  logic [1:0]        push_size,
  input  logic [DATA_W-1:0] push_data,
  output logic              head_valid,
  output logic              head_zero,
  output logic              head_wr,
  output logic [1:0]        head_size,
  output logic [DATA_W-1:0] head_data,
  output logic              full
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic [DEPTH-1:0] vld;
  logic wr_q [DEPTH];
  logic [1:0] sz_q [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  always_comb begin
    head_valid = vld[head];
    head_zero = cnt_q[head] == '0;
    head_wr = wr_q[head];
    head_size = sz_q[head];
    head_data = dat_q[head];
    full = count == FULL_CNT;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (vld[i] && cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 3'd1;
      if (pop) begin
        vld[head] <= 1'b0;
        head <= head == LAST ? '0 : head + 1'b1;
      end
      if (push) begin
        vld[tail] <= 1'b1;
        wr_q[tail] <= push_wr;
        sz_q[tail] <= push_size;
        dat_q[tail] <= push_data;
        cnt_q[tail] <= DELAY;
        tail <= tail == LAST ? '0 : tail + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/sram_like_dmem.sv
// sram_like_dmem: word-organized data memory answering SRAM-like requests in order after a set delay
module sram_like_dmem
  import sram_like_dmem_pkg::*;
#(
  parameter int MEM_AW = 12,
  parameter int QDEPTH = 2,
  parameter int RESP_DELAY = 1
) (
  input logic clk,
  input logic resetn,
  sram_like_dmem_if.slave bus
);
  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] widx;
  logic accept, head_valid, head_zero, head_wr, full;
  logic [DATA_W-1:0] head_data;
  logic [1:0] unused_head_size;
  logic unused_addr;
  always_comb begin
    widx = bus.addr[MEM_AW+1:2];
    unused_addr = ^{bus.addr[ADDR_W-1:MEM_AW+2], bus.addr[1:0]};
    bus.addr_ok = resetn & ~full;
    accept = bus.req & bus.addr_ok;
    bus.data_ok = resetn & head_valid & head_zero & ~bus.resp_hold;
    bus.rdata = bus.data_ok & ~head_wr ? head_data : '0;
  end
  always_ff @(posedge clk)
    if (accept && bus.wr)
      for (int b = 0; b < STRB_W; b++)
        if (bus.wstrb[b]) mem[widx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
  dmem_resp_queue #(.DEPTH(QDEPTH), .DELAY(CNT_W'(RESP_DELAY))) u_queue (
    .clk(clk),
    .resetn(resetn),
    .push(accept),
    .pop(bus.data_ok),
    .push_wr(bus.wr),
    .push_size(bus.size),
    .push_data(mem[widx]),
    .head_valid(head_valid),
    .head_zero(head_zero),
    .head_wr(head_wr),
    .head_size(unused_head_size),
    .head_data(head_data),
    .full(full)
  );
endmodule

// File: tb/tb_sram_like_dmem.sv
// tb_sram_like_dmem: directed checks of latency, strobes, full queue, back-pressure, wrap and reset
module tb_sram_like_dmem;
  import sram_like_dmem_pkg::*;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int tests = 0;
  int fails = 0;
  logic req_d [2];
  logic wr_d [2];
  logic hold_d [2];
  logic [31:0] addr_d [2];
  logic [31:0] wdata_d [2];
  logic [3:0] strb_d [2];
  logic aok [2];
  logic dok [2];
  logic [31:0] rd [2];
  logic [31:0] fq_addr [6] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8};
  logic fq_aok [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic fq_dok [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] fq_rd [11] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h11111111, 32'h22222222,
                              32'h0, 32'h0, 32'h0, 32'h33333333, 32'h0};
  always #5 clk = ~clk;
  sram_like_dmem_if b0();
  sram_like_dmem_if b1();
  assign b0.req = req_d[0];
  assign b0.wr = wr_d[0];
  assign b0.size = SZ_W;
  assign b0.addr = addr_d[0];
  assign b0.wstrb = strb_d[0];
  assign b0.wdata = wdata_d[0];
  assign b0.resp_hold = hold_d[0];
  assign aok[0] = b0.addr_ok;
  assign dok[0] = b0.data_ok;
  assign rd[0] = b0.rdata;
  assign b1.req = req_d[1];
  assign b1.wr = wr_d[1];
  assign b1.size = SZ_W;
  assign b1.addr = addr_d[1];
  assign b1.wstrb = strb_d[1];
  assign b1.wdata = wdata_d[1];
  assign b1.resp_hold = hold_d[1];
  assign aok[1] = b1.addr_ok;
  assign dok[1] = b1.data_ok;
  assign rd[1] = b1.rdata;
  sram_like_dmem #(.MEM_AW(12), .QDEPTH(2), .RESP_DELAY(1)) u0 (.clk(clk), .resetn(resetn), .bus(b0));
  sram_like_dmem #(.MEM_AW(12), .QDEPTH(2), .RESP_DELAY(3)) u1 (.clk(clk), .resetn(resetn), .bus(b1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input int s, input logic w, input logic [31:0] a, input logic [3:0] st,
                       input logic [31:0] d);
    req_d[s] = 1'b1;
    wr_d[s] = w;
    addr_d[s] = a;
    strb_d[s] = st;
    wdata_d[s] = d;
    #1 chk($sformatf("addr_ok u%0d @%0h", s, a), 32'(aok[s]), 32'd1);
    @(negedge clk);
    req_d[s] = 1'b0;
  endtask
  task automatic resp(input int s, input string tag, input logic [31:0] exp, input int lat);
    int c = 1;
    while (!dok[s] && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_lat"}, 32'(c), 32'(lat));
    chk({tag, "_data"}, rd[s], exp);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(dok[s]), 32'd0);
  endtask
  initial begin
    logic seen;
    for (int i = 0; i < 2; i++) begin
      req_d[i] = 1'b0;
      wr_d[i] = 1'b0;
      hold_d[i] = 1'b0;
      addr_d[i] = '0;
      wdata_d[i] = '0;
      strb_d[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_addr_ok", 32'(aok[0]), 32'd0);
    chk("rst_data_ok", 32'(dok[0]), 32'd0);
    chk("rst_rdata", rd[0], 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_addr_ok", 32'(aok[0]), 32'd1);
    issue(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
    resp(0, "wr_word", 32'h0, 2);
    issue(0, 1'b0, 32'h100, 4'h0, 32'h0);
    resp(0, "rd_word", 32'hDEADBEEF, 2);
    issue(0, 1'b1, 32'h102, 4'b0100, 32'h00AA0000);
    resp(0, "wr_byte", 32'h0, 2);
    issue(0, 1'b0, 32'h100, 4'h0, 32'h0);
    resp(0, "rd_byte", 32'hDEAABEEF, 2);
    issue(0, 1'b1, 32'h100, 4'h0, 32'hFFFFFFFF);
    resp(0, "wr_nostrb", 32'h0, 2);
    issue(0, 1'b0, 32'h100, 4'h0, 32'h0);
    resp(0, "rd_nostrb", 32'hDEAABEEF, 2);
    issue(0, 1'b1, 32'h4000, 4'hF, 32'h12345678);
    resp(0, "wr_wrap", 32'h0, 2);
    issue(0, 1'b0, 32'h0, 4'h0, 32'h0);
    resp(0, "rd_wrap", 32'h12345678, 2);
    issue(0, 1'b0, 32'h3, 4'h0, 32'h0);
    resp(0, "rd_lowbits", 32'h12345678, 2);
    hold_d[0] = 1'b1;
    issue(0, 1'b0, 32'h100, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_dok_%0d", i), 32'(dok[0]), 32'd0);
      chk($sformatf("hold_rdata_%0d", i), rd[0], 32'h0);
      @(negedge clk);
    end
    hold_d[0] = 1'b0;
    #1 chk("hold_release_dok", 32'(dok[0]), 32'd1);
    chk("hold_release_data", rd[0], 32'hDEAABEEF);
    @(negedge clk);
    chk("hold_single_pulse", 32'(dok[0]), 32'd0);
    issue(1, 1'b1, 32'h0, 4'hF, 32'h11111111);
    resp(1, "u1_wr0", 32'h0, 4);
    issue(1, 1'b1, 32'h4, 4'hF, 32'h22222222);
    resp(1, "u1_wr4", 32'h0, 4);
    issue(1, 1'b1, 32'h8, 4'hF, 32'h33333333);
    resp(1, "u1_wr8", 32'h0, 4);
    for (int c = 0; c < 11; c++) begin
      req_d[1] = c < 6;
      wr_d[1] = 1'b0;
      addr_d[1] = c < 6 ? fq_addr[c] : 32'h0;
      #1;
      if (c < 6) chk($sformatf("full_aok_%0d", c), 32'(aok[1]), 32'(fq_aok[c]));
      chk($sformatf("full_dok_%0d", c), 32'(dok[1]), 32'(fq_dok[c]));
      chk($sformatf("full_rdata_%0d", c), rd[1], fq_rd[c]);
      @(negedge clk);
    end
    issue(1, 1'b1, 32'h200, 4'hF, 32'hCAFEF00D);
    issue(1, 1'b0, 32'h200, 4'h0, 32'h0);
    resetn = 1'b0;
    seen = dok[1];
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      seen |= dok[1];
      @(negedge clk);
    end
    chk("midrst_no_dok", 32'(seen), 32'd0);
    chk("midrst_aok", 32'(aok[1]), 32'd1);
    issue(1, 1'b0, 32'h200, 4'h0, 32'h0);
    resp(1, "midrst_rd", 32'hCAFEF00D, 4);
    issue(0, 1'b0, 32'h0, 4'h0, 32'h0);
    resp(0, "persist_rd", 32'h12345678, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
